// File: rtl/alu_16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_16_pkg
//  Description : Shared constants for the alu_16 arithmetic unit.
//                Holds the opcode encoding, the FSM state encoding and the
//                iteration count of the sequential multiply/divide engine.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_16_pkg;

  // Number of shift-add / restoring iterations for one mul or div.
  localparam int ITER = 16;

  // Opcode encoding. Any opcode with bit 2 set is reserved and yields 0.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  // Top-level FSM state encoding.
  localparam int         ST_W    = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

endpackage : alu_16_pkg
`default_nettype wire

// File: rtl/alu_16_seqmd.sv
`default_nettype none
// ============================================================================
//  Module      : alu_16_seqmd
//  Description : Iterative unsigned magnitude multiply / divide engine.
//                mode_i=0 : shift-add multiply, mag_o = low WIDTH bits of
//                           a_mag_i * b_mag_i.
//                mode_i=1 : restoring divide, mag_o = a_mag_i / b_mag_i
//                           (quotient only; b_mag_i=0 gives all ones and must
//                           be handled by the caller).
//                Operands are loaded on the edge where go_i=1; the following
//                ITER edges each perform one iteration.
//  Ports       : clk      in   clock
//                reset    in   synchronous active-high reset
//                go_i     in   load operands and start
//                mode_i   in   0 = multiply, 1 = divide
//                a_mag_i  in   WIDTH+1 bit multiplicand / dividend magnitude
//                b_mag_i  in   WIDTH+1 bit multiplier / divisor magnitude
//                mag_o    out  WIDTH bit magnitude result
//                busy_o   out  iterations in progress
//                last_o   out  the upcoming edge performs the final iteration
//  Revision    : 1.0  initial release
// ============================================================================
module alu_16_seqmd
  import alu_16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go_i,
  input  logic             mode_i,
  input  logic [WIDTH:0]   a_mag_i,
  input  logic [WIDTH:0]   b_mag_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             busy_o,
  output logic             last_o
);

  localparam int             MW     = WIDTH + 1;
  localparam int             CW     = $clog2(ITER);
  localparam logic [CW-1:0]  C_LAST = CW'(ITER - 1);

  // a_q : multiplicand (shifted left)  / partial remainder
  // b_q : multiplier   (shifted right) / divisor
  // p_q : product accumulator          / dividend-in, quotient-out shifter
  logic [MW-1:0] a_q, a_d;
  logic [MW-1:0] b_q, b_d;
  logic [MW-1:0] p_q, p_d;
  logic          mode_q, mode_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [MW-1:0] w_sum;
  logic [MW-1:0] w_shift;
  logic [MW:0]   w_trial;
  logic          w_trial_ok;

  // Restoring step: bring the next dividend bit into the remainder and try
  // to subtract the divisor; the extra top bit of w_trial is the borrow.
  assign w_sum      = p_q + a_q;
  assign w_shift    = {a_q[WIDTH-1:0], p_q[WIDTH-1]};
  assign w_trial    = {1'b0, w_shift} - {1'b0, b_q};
  assign w_trial_ok = ~w_trial[MW];

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    p_d    = p_q;
    mode_d = mode_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (go_i) begin
      mode_d = mode_i;
      busy_d = 1'b1;
      cnt_d  = '0;
      b_d    = b_mag_i;
      if (mode_i) begin
        a_d = '0;
        p_d = a_mag_i;
      end else begin
        a_d = a_mag_i;
        p_d = '0;
      end
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == C_LAST) begin
        busy_d = 1'b0;
      end
      if (mode_q) begin
        a_d = w_trial_ok ? w_trial[MW-1:0] : w_shift;
        p_d = {1'b0, p_q[WIDTH-2:0], w_trial_ok};
      end else begin
        if (b_q[0]) begin
          p_d = w_sum;
        end
        a_d = {a_q[MW-2:0], 1'b0};
        b_d = {1'b0, b_q[MW-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      mode_q <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      p_q    <= p_d;
      mode_q <= mode_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mag_o  = p_q[WIDTH-1:0];
  assign busy_o = busy_q;
  assign last_o = busy_q && (cnt_q == C_LAST);

endmodule : alu_16_seqmd
`default_nettype wire

// File: rtl/alu_16.sv
`default_nettype none
// ============================================================================
//  Module      : alu_16
//  Description : Signed multi-cycle ALU with start/done handshake.
//                add/sub/reserved complete on the start edge; mul/div run on
//                the shared magnitude engine for ITER cycles, then a FIN
//                cycle applies the sign and writes the result.
//  Ports       : clk     in   clock
//                reset   in   synchronous active-high reset
//                start   in   request, sampled only in IDLE
//                opcode  in   000 add, 001 sub, 010 mul, 011 div, 1xx -> 0
//                A       in   signed operand (dividend / multiplicand)
//                B       in   signed operand (divisor / multiplier)
//                result  out  registered signed result
//                done    out  registered one-cycle completion pulse
//  Revision    : 1.0  initial release
// ============================================================================
module alu_16
  import alu_16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  logic [ST_W-1:0]  state_q, state_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic             w_accept;
  logic             w_go;
  logic [WIDTH:0]   w_a_ext, w_b_ext;
  logic [WIDTH:0]   w_a_mag, w_b_mag;
  logic [WIDTH-1:0] w_mag;
  logic [WIDTH-1:0] w_fixed;
  logic             w_eng_busy;
  logic             w_eng_last;

  // Magnitudes are one bit wider so that the most negative operand is exact.
  assign w_a_ext = {A[WIDTH-1], A};
  assign w_b_ext = {B[WIDTH-1], B};
  assign w_a_mag = A[WIDTH-1] ? ('0 - w_a_ext) : w_a_ext;
  assign w_b_mag = B[WIDTH-1] ? ('0 - w_b_ext) : w_b_ext;

  assign w_accept = (state_q == ST_IDLE) && start;
  assign w_go     = w_accept && ((opcode == OP_MUL) || (opcode == OP_DIV));

  alu_16_seqmd #(
    .WIDTH (WIDTH)
  ) u_seqmd (
    .clk     (clk),
    .reset   (reset),
    .go_i    (w_go),
    .mode_i  (opcode == OP_DIV),
    .a_mag_i (w_a_mag),
    .b_mag_i (w_b_mag),
    .mag_o   (w_mag),
    .busy_o  (w_eng_busy),
    .last_o  (w_eng_last)
  );

  // Sign fix-up; a zero divisor forces the result to 0 regardless of the
  // all-ones quotient the restoring engine produces.
  assign w_fixed = zero_q ? '0 : (sign_q ? ('0 - w_mag) : w_mag);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (w_go) begin
          sign_d  = A[WIDTH-1] ^ B[WIDTH-1];
          zero_d  = (opcode == OP_DIV) && (B == '0);
          state_d = (opcode == OP_DIV) ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        // An idle engine here would mean the two sides lost step; fall
        // back to IDLE instead of waiting forever.
        if (!w_eng_busy) begin
          state_d = ST_IDLE;
        end else if (w_eng_last) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    result_d = result_q;
    done_d   = 1'b0;
    if (w_accept) begin
      case (opcode)
        OP_ADD: begin
          result_d = A + B;
          done_d   = 1'b1;
        end
        OP_SUB: begin
          result_d = A - B;
          done_d   = 1'b1;
        end
        OP_MUL, OP_DIV: begin
          result_d = result_q;
        end
        default: begin
          result_d = '0;
          done_d   = 1'b1;
        end
      endcase
    end else if (state_q == ST_FIN) begin
      result_d = w_fixed;
      done_d   = 1'b1;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule : alu_16
`default_nettype wire

// File: tb/tb_alu_16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_16
//  Description : Scoreboard testbench for alu_16. Stimulus pushes the
//                expected result and completion cycle; a monitor pops and
//                compares on every done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_16;
  import alu_16_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  opcode;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] result;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] res;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t sb[$];

  alu_16 #(.WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .opcode (opcode),
    .A      (A),
    .B      (B),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got done with result=%0d at cycle %0d, required no done",
                 $signed(result), cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res || cyc != e.cyc) begin
          bad++;
          $display("FAIL %s: got result=%0d at cycle %0d, required result=%0d at cycle %0d",
                   e.nm, $signed(result), cyc, $signed(e.res), e.cyc);
        end
      end
    end
  end

  function automatic logic [15:0] model(input logic [2:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    int ia;
    int ib;
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      OP_ADD:  return 16'(ia + ib);
      OP_SUB:  return 16'(ia - ib);
      OP_MUL:  return 16'(ia * ib);
      OP_DIV:  return (ib == 0) ? 16'd0 : 16'(ia / ib);
      default: return 16'd0;
    endcase
  endfunction

  // Drive one start pulse and record what should come back and when.
  task automatic launch(input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_res,
                        input string nm);
    int lat;
    lat = (op == OP_MUL || op == OP_DIV) ? 17 : 0;
    @(negedge clk);
    start  = 1'b1;
    opcode = op;
    A      = a;
    B      = b;
    sb.push_back('{exp_res, cyc + 1 + lat, nm});
    @(negedge clk);
    start  = 1'b0;
    opcode = 3'($urandom);
    A      = 16'($urandom);
    B      = 16'($urandom);
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d expectations still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] exp_res,
                     input string nm);
    launch(op, a, b, exp_res, nm);
    drain();
  endtask

  task automatic check(input string nm, input logic [15:0] got,
                       input logic [15:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, $signed(got), $signed(req));
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    opcode = 3'd0;
    A      = 16'h1234;
    B      = 16'h5678;
    repeat (3) @(negedge clk);
    check("reset_result", result, 16'd0);
    check("reset_done", {15'd0, done}, 16'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_no_done", {15'd0, done}, 16'd0);

    // Add / sub / reserved
    run(OP_ADD, 16'd100, 16'(-300), 16'(-200), "add_100_m300");
    run(OP_SUB, 16'd100, 16'(-300), 16'd400, "sub_100_m300");
    run(3'b101, 16'd5, 16'd6, 16'd0, "reserved_op");
    run(OP_ADD, 16'd32767, 16'd1, 16'h8000, "add_wrap");

    // Multiply
    run(OP_MUL, 16'(-123), 16'd45, 16'(-5535), "mul_m123_45");
    run(OP_MUL, 16'h8000, 16'hFFFF, 16'h8000, "mul_min_m1");
    run(OP_MUL, 16'd300, 16'd300, 16'd24464, "mul_300_300");

    // Divide
    run(OP_DIV, 16'(-7), 16'd2, 16'(-3), "div_m7_2");
    run(OP_DIV, 16'd7, 16'(-2), 16'(-3), "div_7_m2");
    run(OP_DIV, 16'h8000, 16'hFFFF, 16'h8000, "div_min_m1");
    run(OP_DIV, 16'd1234, 16'd0, 16'd0, "div_by_zero");

    // Back-to-back: start held high across an add then a mul
    @(negedge clk);
    start = 1'b1; opcode = OP_ADD; A = 16'd2; B = 16'd3;
    sb.push_back('{16'd5, cyc + 1, "b2b_add"});
    @(negedge clk);
    opcode = OP_MUL; A = 16'd7; B = 16'(-6);
    sb.push_back('{16'(-42), cyc + 1 + 17, "b2b_mul"});
    @(negedge clk);
    start = 1'b0; A = 16'd0; B = 16'd0;
    drain();

    // Start while busy is ignored
    launch(OP_MUL, 16'd111, 16'd3, 16'd333, "mul_busy_start");
    repeat (4) @(negedge clk);
    start = 1'b1; opcode = OP_ADD; A = 16'd1; B = 16'd1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    check("busy_result_holds", result, 16'd333);

    // Reset in the middle of a divide aborts it without a done pulse
    @(negedge clk);
    start = 1'b1; opcode = OP_DIV; A = 16'd1000; B = 16'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_result", result, 16'd0);
    repeat (25) @(negedge clk);
    check("abort_result_later", result, 16'd0);
    check("abort_no_done", {15'd0, done}, 16'd0);

    // Sweep against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'(-32768 + 813 * i);
      b = 16'(-32768 + 512 * ((i * 5) % 128));
      for (int op = 0; op < 4; op++) begin
        run(3'(op), a, b, model(3'(op), a, b), "sweep");
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule : tb_alu_16
`default_nettype wire
